// File: rtl/array_pkg.sv
// ============================================================================
// Module : array_pkg
// Brief  : Shared types, widths and mux mapping for the receive-array scanner.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package array_pkg;

    localparam int ROW_W               = 3;
    localparam int COL_W               = 4;
    localparam int PLEX_BASE           = 3;
    localparam int INPUTS_PER_ROW_PAIR = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_EMIT    = 3'd3,
        ST_ADVANCE = 3'd4
    } scan_state_e;

    // Two rows share one plex; odd rows sit on the upper nine mux inputs.
    function automatic logic [5:0] mux_select(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        logic [1:0]       plex;
        logic [COL_W-1:0] inp;
        plex = 2'(PLEX_BASE) - row[2:1];
        inp  = col + (row[0] ? COL_W'(INPUTS_PER_ROW_PAIR) : COL_W'(0));
        return {plex, inp};
    endfunction

endpackage

`default_nettype wire

// File: rtl/array_scan_sequencer_window_counter.sv
// ============================================================================
// Module : window_counter
// Brief  : Counts high input samples over a fixed window of enabled cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module window_counter #(
    parameter int SAMPLE_CYCLES = 128,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_din,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    localparam int              IDX_W    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_CYCLES - 1);

    logic [CNT_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_en) begin
            r_acc <= o_count;
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Count includes the current sample so the total is usable on the done cycle.
    assign o_count = r_acc + CNT_W'(i_en & i_din);
    assign o_done  = i_en && (r_idx == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/array_scan_sequencer.sv
// ============================================================================
// Module : array_scan_sequencer
// Brief  : Row-major scan of the receive array: settle, sample, emit result.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module array_scan_sequencer
    import array_pkg::*;
#(
    parameter int ROWS          = 7,
    parameter int COLS          = 7,
    parameter int SETTLE_CYCLES = 64,
    parameter int SAMPLE_CYCLES = 128,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic             diff_in,
    output logic [1:0]       uplex,
    output logic [3:0]       uinput,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ROW_W-1:0] res_row,
    output logic [COL_W-1:0] res_col,
    output logic [CNT_W-1:0] res_count,
    output logic             frame_done
);

    localparam int               TMR_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL    = COL_W'(COLS - 1);

    scan_state_e      r_state;
    scan_state_e      w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic             w_xfer;
    logic             w_last_elem;
    logic [CNT_W-1:0] w_win_count;
    logic             w_win_done;

    window_counter #(
        .SAMPLE_CYCLES (SAMPLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state != ST_SAMPLE),
        .i_en    (r_state == ST_SAMPLE),
        .i_din   (diff_in),
        .o_count (w_win_count),
        .o_done  (w_win_done)
    );

    assign w_xfer      = res_valid & res_ready;
    assign w_last_elem = (r_row == LAST_ROW) && (r_col == LAST_COL);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (r_timer == SETTLE_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_win_done) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_xfer) begin
                    w_state_nxt = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (w_last_elem) begin
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = continuous ? ST_SETTLE : ST_IDLE;
                end else if (r_col == LAST_COL) begin
                    w_col_nxt   = '0;
                    w_row_nxt   = r_row + ROW_W'(1);
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_col_nxt   = r_col + COL_W'(1);
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over start and over a same-cycle transfer.
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_row_nxt   = r_row;
            w_col_nxt   = r_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            uplex      <= 2'(PLEX_BASE);
            uinput     <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_row    <= '0;
            res_col    <= '0;
            res_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_row           <= w_row_nxt;
            r_col           <= w_col_nxt;
            {uplex, uinput} <= mux_select(w_row_nxt, w_col_nxt);
            busy            <= (w_state_nxt != ST_IDLE);
            r_timer         <= (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE)
                               ? r_timer + TMR_W'(1) : '0;
            frame_done      <= (r_state == ST_EMIT) && w_xfer && w_last_elem && !abort;

            if (abort) begin
                res_valid <= 1'b0;
            end else if (r_state == ST_SAMPLE && w_win_done) begin
                res_valid <= 1'b1;
                res_row   <= r_row;
                res_col   <= r_col;
                res_count <= w_win_count;
            end else if (w_xfer) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_array_scan_sequencer.sv
// ============================================================================
// Module : tb_array_scan_sequencer
// Brief  : Self-checking bench with a cycle-history reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_array_scan_sequencer;

    localparam int ROWS   = 7;
    localparam int COLS   = 7;
    localparam int SETTLE = 64;
    localparam int SAMPLE = 128;
    localparam int CNT_W  = 16;
    localparam int NEL    = ROWS * COLS;
    localparam int NT     = 5;
    localparam int HMAX   = 100000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic             abort = 1'b0;
    logic             diff_in = 1'b0;
    logic             res_ready = 1'b0;
    logic [1:0]       uplex;
    logic [3:0]       uinput;
    logic             busy;
    logic             res_valid;
    logic [2:0]       res_row;
    logic [3:0]       res_col;
    logic [CNT_W-1:0] res_count;
    logic             frame_done;

    array_scan_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE),
        .SAMPLE_CYCLES(SAMPLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .abort(abort), .diff_in(diff_in), .uplex(uplex), .uinput(uinput),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .res_col(res_col), .res_count(res_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit hist [0:HMAX-1];
    bit m_on = 1'b0, m_adv = 1'b0;
    int m_anchor = 0, m_idx = 0, m_exp_cnt = 0;
    int fd_cyc = -1, idle_chk = -1, n_fd = 0;
    int emit_cyc, mr, mc;
    logic [31:0] exp_pack;

    function automatic logic [31:0] pack_out(input int r, input int c, input int cnt);
        return {2'b0, 1'b1, 3'(r), 4'(c), 16'(cnt), 2'(3 - r / 2), 4'(c + (r % 2) * 9)};
    endfunction

    always @(negedge clk) begin
        if (cyc < HMAX) hist[cyc] = diff_in;
        if (!rst_n) begin
            m_on = 1'b0; m_adv = 1'b0; fd_cyc = -1; idle_chk = -1;
        end else begin
            if (frame_done) n_fd++;
            if (frame_done || cyc == fd_cyc) check("frame_done", 32'(frame_done), 32'(cyc == fd_cyc));
            if (cyc == idle_chk) begin
                check("idle busy", 32'(busy), 0);
                check("idle res_valid", 32'(res_valid), 0);
            end
            emit_cyc = m_anchor + 1 + SETTLE + SAMPLE;
            mr = m_idx / COLS;
            mc = m_idx % COLS;
            if (abort) begin
                if (m_on) idle_chk = cyc + 1;
                m_on = 1'b0; m_adv = 1'b0;
            end else if (m_adv) begin
                m_adv = 1'b0;
                check("advance busy", 32'(busy), 1);
                if (m_idx == NEL) begin
                    if (continuous) m_idx = 0;
                    else begin m_on = 1'b0; idle_chk = cyc + 1; end
                end
            end else if (m_on) begin
                if (cyc == m_anchor + 1) begin
                    check("settle busy", 32'(busy), 1);
                    check("settle uplex", 32'(uplex), 32'(3 - mr / 2));
                    check("settle uinput", 32'(uinput), 32'(mc + (mr % 2) * 9));
                end
                if (cyc == emit_cyc - 1) check("valid early", 32'(res_valid), 0);
                if (cyc >= emit_cyc) begin
                    if (cyc == emit_cyc) begin
                        m_exp_cnt = 0;
                        for (int i = m_anchor + 1 + SETTLE; i <= m_anchor + SETTLE + SAMPLE; i++)
                            m_exp_cnt += int'(hist[i]);
                    end
                    exp_pack = pack_out(mr, mc, m_exp_cnt);
                    check(cyc == emit_cyc ? "result" : "stall hold",
                          {2'b0, res_valid, res_row, res_col, res_count, uplex, uinput}, exp_pack);
                    if (res_ready) begin
                        m_idx++;
                        m_anchor = cyc + 1;
                        m_adv = 1'b1;
                        if (m_idx == NEL) fd_cyc = cyc + 1;
                    end
                end
            end else if (start) begin
                m_on = 1'b1; m_anchor = cyc; m_idx = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct { int mode; int hold; int exp_count; } vec_t;
    vec_t tbl [NT];
    int vcnt = 0;
    int budget;

    function automatic logic pattern(input int mode, input int c);
        case (mode)
            1:       return 1'b1;
            2:       return 1'(c % 2);
            3:       return 1'(c % 4 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input bit rnd);
        @(posedge clk); #1;
        start = 1'b0;
        if (rnd) begin
            diff_in   = 1'($urandom % 2);
            res_ready = (($urandom % 4) != 0);
        end else begin
            diff_in = pattern(tbl[m_idx % NT].mode, cyc);
            if (res_valid) vcnt++; else vcnt = 0;
            res_ready = (vcnt > tbl[m_idx % NT].hold);
        end
    endtask

    task automatic run_frame(input bit rnd, input string tag);
        start = 1'b1;
        n_fd = 0;
        budget = 0;
        do begin
            step(rnd);
            budget++;
            if (!rnd && res_valid && res_ready)
                check({tag, " tbl count"}, 32'(res_count), 32'(tbl[m_idx % NT].exp_count));
        end while ((m_on || m_adv) && budget < 16000);
        check({tag, " timeout"}, 32'(budget < 16000), 1);
        step(rnd); step(rnd);
        check({tag, " done busy"}, 32'(busy), 0);
        check({tag, " frame_done count"}, 32'(n_fd), 1);
    endtask

    initial begin
        tbl[0] = '{mode: 1, hold: 20, exp_count: 128};
        tbl[1] = '{mode: 0, hold: 0,  exp_count: 0};
        tbl[2] = '{mode: 2, hold: 0,  exp_count: 64};
        tbl[3] = '{mode: 1, hold: 0,  exp_count: 128};
        tbl[4] = '{mode: 3, hold: 0,  exp_count: 32};

        repeat (3) @(posedge clk);
        #1;
        check("rst uplex", 32'(uplex), 3);
        check("rst uinput", 32'(uinput), 0);
        check("rst busy", 32'(busy), 0);
        check("rst res_valid", 32'(res_valid), 0);
        check("rst res_row", 32'(res_row), 0);
        check("rst res_col", 32'(res_col), 0);
        check("rst res_count", 32'(res_count), 0);
        check("rst frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        budget = 0;
        repeat (100) begin
            step(1'b1);
            if (busy || res_valid || frame_done) budget++;
        end
        check("idle 100 cycles active", 32'(budget), 0);

        run_frame(1'b0, "table frame");
        run_frame(1'b1, "random frame");

        // Abort during SAMPLE of element (2,4).
        start = 1'b1;
        n_fd = 0;
        budget = 0;
        do begin step(1'b1); budget++; end
        while (!(m_on && m_idx == 2 * COLS + 4 && cyc == m_anchor + SETTLE + 11) && budget < 8000);
        check("abort reach", 32'(budget < 8000), 1);
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        step(1'b1); step(1'b1);
        check("abort busy", 32'(busy), 0);
        check("abort frame_done count", 32'(n_fd), 0);

        // Continuous: frame 2 restarts at (0,0) without passing through IDLE.
        continuous = 1'b1;
        start = 1'b1;
        n_fd = 0;
        budget = 0;
        do begin step(1'b1); budget++; end
        while (!(n_fd == 1 && m_idx == 2 && !m_adv) && budget < 16000);
        check("continuous reach", 32'(budget < 16000), 1);
        check("continuous still busy", 32'(busy), 1);
        continuous = 1'b0;
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        step(1'b1); step(1'b1);
        check("continuous abort busy", 32'(busy), 0);

        // Asynchronous reset mid-frame.
        start = 1'b1;
        repeat (500) step(1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 0);
        check("midrst res_valid", 32'(res_valid), 0);
        check("midrst uplex", 32'(uplex), 3);
        check("midrst uinput", 32'(uinput), 0);
        check("midrst res_count", 32'(res_count), 0);
        step(1'b1);
        rst_n = 1'b1;
        step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
